// File: rtl/spi_mem_responder_if.sv
// ----------------------------------------------------------------------------
// spi_mem_responder_if
//   Bundles the SPI pins, the status strobes and the backdoor port of the
//   SPI memory responder.
//   master : the controller / bench side. It drives sck, ce, si and the
//            backdoor request (bk_we, bk_addr, bk_wdata).
//   slave  : the responder. It drives so, busy, txn_done, cmd_err, bk_rdata.
// ----------------------------------------------------------------------------
interface spi_mem_responder_if #(
    parameter int ADDR_W = 10
);
    logic              sck;
    logic              ce;
    logic              si;
    logic              so;
    logic              busy;
    logic              txn_done;
    logic              cmd_err;
    logic              bk_we;
    logic [ADDR_W-1:0] bk_addr;
    logic [7:0]        bk_wdata;
    logic [7:0]        bk_rdata;

    modport master (
        output sck, ce, si, bk_we, bk_addr, bk_wdata,
        input  so, busy, txn_done, cmd_err, bk_rdata
    );

    modport slave (
        input  sck, ce, si, bk_we, bk_addr, bk_wdata,
        output so, busy, txn_done, cmd_err, bk_rdata
    );
endinterface

// File: rtl/spi_mem_responder.sv
// ----------------------------------------------------------------------------
// spi_mem_responder
//   SPI mode-0 memory target for the serial read (0x03) / write (0x02)
//   protocol: 8-bit command, 24-bit address, then byte-serial data, MSB
//   first. Backed by a 2**ADDR_W byte array with a backdoor port for preload
//   and inspection. sck, ce and si are oversampled on i_clk; nothing is
//   clocked by sck.
// Ports
//   i_clk    : system clock, at least 8x the sck frequency
//   i_reset  : synchronous, active-high
//   bus      : slave side of spi_mem_responder_if
//              sck/ce/si in, so out, busy/txn_done/cmd_err status,
//              bk_we/bk_addr/bk_wdata in, bk_rdata out (registered)
// ----------------------------------------------------------------------------
module spi_mem_responder #(
    parameter int ADDR_W         = 10,
    parameter bit CE_ACTIVE_HIGH = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    spi_mem_responder_if.slave   bus
);
    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [7:0]       CMD_RD  = 8'h03;
    localparam logic [7:0]       CMD_WR  = 8'h02;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // ---------------------------------------------------------------- sync
    logic r_sck_s1, r_sck_s2, r_sck_d;
    logic r_ce_s1,  r_ce_s2;
    logic r_si_s1,  r_si_s2;

    always_ff @(posedge i_clk) begin
        r_sck_s1 <= bus.sck;
        r_sck_s2 <= r_sck_s1;
        r_sck_d  <= r_sck_s2;
        r_ce_s1  <= bus.ce;
        r_ce_s2  <= r_ce_s1;
        r_si_s1  <= bus.si;
        r_si_s2  <= r_si_s1;
    end

    logic w_rise, w_fall, w_ce_act, w_si;
    assign w_rise   = r_sck_s2 & ~r_sck_d;
    assign w_fall   = ~r_sck_s2 & r_sck_d;
    assign w_ce_act = CE_ACTIVE_HIGH ? r_ce_s2 : ~r_ce_s2;
    assign w_si     = r_si_s2;

    // ---------------------------------------------------------------- state
    state_t            r_state;
    logic [4:0]        r_bitcnt;
    logic [7:0]        r_cmd;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_wbyte;
    logic [7:0]        r_shift;
    logic [7:0]        r_rd_q;
    logic              r_wr_pend;
    logic              r_moved;
    logic              r_ce_act_d;
    logic              r_so;
    logic              r_busy;
    logic              r_txn_done;
    logic              r_cmd_err;
    logic [7:0]        r_bk_rdata;

    logic [7:0]        w_cmd_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [7:0]        w_wbyte_nxt;
    assign w_cmd_nxt   = {r_cmd[6:0], w_si};
    // Shifting all 24 address bits through an ADDR_W-wide register keeps
    // exactly addr[ADDR_W-1:0]; the upper bits fall off the top.
    assign w_ptr_nxt   = {r_ptr[ADDR_W-2:0], w_si};
    assign w_wbyte_nxt = {r_wbyte[6:0], w_si};

    // ---------------------------------------------------------------- array
    logic [7:0] r_mem [DEPTH];

    // One write port shared by SPI and backdoor. A pending SPI write only
    // exists while busy is still high, and the backdoor is locked out then,
    // so the two can never collide.
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [7:0]        w_mem_wdata;
    assign w_mem_we    = ~i_reset & (r_wr_pend | (bus.bk_we & ~r_busy));
    assign w_mem_waddr = r_wr_pend ? r_ptr   : bus.bk_addr;
    assign w_mem_wdata = r_wr_pend ? r_wbyte : bus.bk_wdata;

    // Contents survive reset. r_rd_q continuously follows r_ptr, so a byte
    // is ready two clocks after the pointer moves, well before the next fall.
    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[w_mem_waddr] <= w_mem_wdata;
        r_rd_q <= r_mem[r_ptr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_bk_rdata <= 8'h00;
        else         r_bk_rdata <= r_mem[bus.bk_addr];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 5'd0;
            r_cmd      <= 8'h00;
            r_ptr      <= '0;
            r_wbyte    <= 8'h00;
            r_shift    <= 8'h00;
            r_wr_pend  <= 1'b0;
            r_moved    <= 1'b0;
            // Treat ce as already active so a transaction cut by reset is
            // not picked up mid-stream; a fresh ce assertion is required.
            r_ce_act_d <= 1'b1;
            r_so       <= 1'b0;
            r_busy     <= 1'b0;
            r_txn_done <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_txn_done <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_ce_act_d <= w_ce_act;

            // Completed write byte lands this clk; advance the pointer.
            if (r_wr_pend) begin
                r_wr_pend <= 1'b0;
                r_ptr     <= r_ptr + PTR_ONE;
            end

            if (r_state != S_IDLE && !w_ce_act) begin
                // Release: partial write byte in r_wbyte is simply dropped.
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_so       <= 1'b0;
                r_bitcnt   <= 5'd0;
                r_txn_done <= r_moved;
                r_moved    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ce_act && !r_ce_act_d) begin
                            r_state <= S_CMD;
                            r_busy  <= 1'b1;
                            r_moved <= 1'b0;
                            r_so    <= 1'b0;
                            // A rise coincident with ce assert is the first
                            // command bit.
                            if (w_rise) begin
                                r_cmd    <= w_cmd_nxt;
                                r_bitcnt <= 5'd1;
                            end else begin
                                r_bitcnt <= 5'd0;
                            end
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_cmd <= w_cmd_nxt;
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt <= 5'd0;
                                if (w_cmd_nxt == CMD_RD || w_cmd_nxt == CMD_WR) begin
                                    r_state <= S_ADDR;
                                end else begin
                                    r_state   <= S_IGNORE;
                                    r_cmd_err <= 1'b1;
                                end
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_ptr <= w_ptr_nxt;
                            if (r_bitcnt == 5'd23) begin
                                r_bitcnt <= 5'd0;
                                r_state  <= (r_cmd == CMD_RD) ? S_RDATA : S_WDATA;
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            r_wbyte <= w_wbyte_nxt;
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt  <= 5'd0;
                                r_wr_pend <= 1'b1;
                                r_moved   <= 1'b1;
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_fall) begin
                            // Bit 7 comes straight from the prefetched byte;
                            // the rest walk out of the shift register.
                            if (r_bitcnt == 5'd0) begin
                                r_so    <= r_rd_q[7];
                                r_shift <= {r_rd_q[6:0], 1'b0};
                                r_moved <= 1'b1;
                            end else begin
                                r_so    <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                            // Bit 0 going out: move on so the next byte is
                            // fetched before the following fall.
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt <= 5'd0;
                                r_ptr    <= r_ptr + PTR_ONE;
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        r_so <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_so    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.so       = r_so;
    assign bus.busy     = r_busy;
    assign bus.txn_done = r_txn_done;
    assign bus.cmd_err  = r_cmd_err;
    assign bus.bk_rdata = r_bk_rdata;

endmodule
